// File: rtl/cache_policy_controller_setassoc.sv
// Set-associative replacement-policy engine: fills invalid ways first, then evicts by FIFO or tree-PLRU.
// Optional statistics counters are enabled with the CACHE_POLICY_STATS_EN macro.
module cache_policy_controller_setassoc #(
    parameter int BW_ACCESS_ADDR    = 32,
    parameter int N_CAPACITY_BLOCKS = 256,
    parameter int N_WORDS_PER_BLOCK = 16,
    parameter int ASSOCIATIVITY     = 4,
    parameter int POLICY            = 0
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic [BW_ACCESS_ADDR-1:0]            access_addr_i,
    input  logic [$clog2(N_CAPACITY_BLOCKS)-1:0] cache_addr_i,
    input  logic                                 miss_i,
    input  logic                                 hit_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [$clog2(N_CAPACITY_BLOCKS)-1:0] addr_o
`ifdef CACHE_POLICY_STATS_EN
    ,
    output logic [31:0]                          stat_hits_o,
    output logic [31:0]                          stat_misses_o
`endif
);

    localparam int BW_OFFSET          = $clog2(N_WORDS_PER_BLOCK);
    localparam int BW_CAPACITY_BLOCKS = $clog2(N_CAPACITY_BLOCKS);
    localparam int N_SETS             = N_CAPACITY_BLOCKS / ASSOCIATIVITY;
    localparam int BW_SET             = $clog2(N_SETS);
    localparam int BW_SET_R           = (BW_SET > 0) ? BW_SET : 1;
    localparam int BW_WAY             = $clog2(ASSOCIATIVITY);

    generate
        if (POLICY != 0 && POLICY != 1) begin : g_bad_policy
            $error("cache_policy_controller_setassoc: POLICY must be 0 (FIFO) or 1 (tree-PLRU)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [BW_SET_R-1:0]      miss_set, hit_set, set_q;
    logic [BW_WAY-1:0]        hit_way;
    logic [ASSOCIATIVITY-1:0] valid_q    [N_SETS];
    logic [BW_WAY-1:0]        fifo_ptr_q [N_SETS];
    logic [ASSOCIATIVITY-2:0] plru_q     [N_SETS];

    logic                          has_invalid;
    logic [BW_WAY-1:0]             first_invalid;
    logic [BW_WAY-1:0]             policy_victim;
    logic [BW_WAY-1:0]             victim;
    logic [BW_CAPACITY_BLOCKS-1:0] addr_next;
    logic                          unused_addr_bits;

    // A fully associative configuration has a single set and no index bits.
    generate
        if (BW_SET > 0) begin : g_set_index
            assign miss_set = access_addr_i[BW_OFFSET +: BW_SET];
            assign hit_set  = cache_addr_i[BW_WAY +: BW_SET];
        end else begin : g_single_set
            assign miss_set = '0;
            assign hit_set  = '0;
        end
    endgenerate

    assign hit_way          = cache_addr_i[BW_WAY-1:0];
    assign unused_addr_bits = ^{access_addr_i, cache_addr_i};

    // Walk the heap-ordered tree from the root; a 0 bit sends the victim to the lower half.
    function automatic logic [BW_WAY-1:0] plru_victim(input logic [ASSOCIATIVITY-2:0] bits);
        logic [BW_WAY-1:0] way;
        int                node;
        way  = '0;
        node = 0;
        for (int l = 0; l < BW_WAY; l++) begin
            way[BW_WAY-1-l] = bits[node];
            node            = 2 * node + 1 + (bits[node] ? 1 : 0);
        end
        return way;
    endfunction

    function automatic logic [ASSOCIATIVITY-2:0] plru_touch(input logic [ASSOCIATIVITY-2:0] bits,
                                                            input logic [BW_WAY-1:0] way);
        logic [ASSOCIATIVITY-2:0] result;
        logic                     dir;
        int                       node;
        result = bits;
        node   = 0;
        for (int l = 0; l < BW_WAY; l++) begin
            dir          = way[BW_WAY-1-l];
            result[node] = ~dir;
            node         = 2 * node + 1 + (dir ? 1 : 0);
        end
        return result;
    endfunction

    // Lowest-index invalid way wins over the policy victim.
    always_comb begin
        has_invalid   = 1'b0;
        first_invalid = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (!valid_q[set_q][w]) begin
                has_invalid   = 1'b1;
                first_invalid = BW_WAY'(w);
            end
        end
        policy_victim = (POLICY == 1) ? plru_victim(plru_q[set_q]) : fifo_ptr_q[set_q];
        victim        = has_invalid ? first_invalid : policy_victim;
        addr_next     = BW_CAPACITY_BLOCKS'({set_q, victim});
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                busy_o  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The victim is committed while leaving SELECT so addr_o is stable for the whole DONE cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            addr_o  <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s]    <= '0;
                fifo_ptr_q[s] <= '0;
                plru_q[s]     <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (miss_i) begin
                        set_q <= miss_set;
                    end else if (hit_i && POLICY == 1) begin
                        plru_q[hit_set] <= plru_touch(plru_q[hit_set], hit_way);
                    end
                end
                SELECT: begin
                    addr_o                 <= addr_next;
                    valid_q[set_q][victim] <= 1'b1;
                    if (POLICY == 1) begin
                        plru_q[set_q] <= plru_touch(plru_q[set_q], victim);
                    end else if (!has_invalid) begin
                        fifo_ptr_q[set_q] <= fifo_ptr_q[set_q] + BW_WAY'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_POLICY_STATS_EN
    // Saturating counters of requests accepted in IDLE; a hit colliding with a miss is not counted.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
        end else if (state_q == IDLE) begin
            if (miss_i) begin
                if (stat_misses_o != 32'hFFFF_FFFF) begin
                    stat_misses_o <= stat_misses_o + 32'd1;
                end
            end else if (hit_i) begin
                if (stat_hits_o != 32'hFFFF_FFFF) begin
                    stat_hits_o <= stat_hits_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_policy_controller_setassoc.sv
// Bench for cache_policy_controller_setassoc: FIFO and PLRU instances share one stimulus stream
// and are checked every cycle against a set-level behavioural model plus hand-computed results.
module tb_cache_policy_controller_setassoc;

    localparam int NBLK = 16;
    localparam int WAYS = 4;
    localparam int SETS = NBLK / WAYS;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       miss  = 1'b0;
    logic       hit   = 1'b0;
    logic [7:0] access_addr = '0;
    logic [3:0] cache_addr  = '0;

    logic       busy_f, done_f, busy_p, done_p;
    logic [3:0] addr_f, addr_p;
`ifdef CACHE_POLICY_STATS_EN
    logic [31:0] hits_f, misses_f, hits_p, misses_p;
`endif

    always #5 clock = ~clock;

    cache_policy_controller_setassoc #(
        .BW_ACCESS_ADDR(8), .N_CAPACITY_BLOCKS(NBLK), .N_WORDS_PER_BLOCK(4),
        .ASSOCIATIVITY(WAYS), .POLICY(0)
    ) dut_fifo (
        .clock_i(clock), .reset_i(reset), .access_addr_i(access_addr), .cache_addr_i(cache_addr),
        .miss_i(miss), .hit_i(hit), .busy_o(busy_f), .done_o(done_f), .addr_o(addr_f)
`ifdef CACHE_POLICY_STATS_EN
        , .stat_hits_o(hits_f), .stat_misses_o(misses_f)
`endif
    );

    cache_policy_controller_setassoc #(
        .BW_ACCESS_ADDR(8), .N_CAPACITY_BLOCKS(NBLK), .N_WORDS_PER_BLOCK(4),
        .ASSOCIATIVITY(WAYS), .POLICY(1)
    ) dut_plru (
        .clock_i(clock), .reset_i(reset), .access_addr_i(access_addr), .cache_addr_i(cache_addr),
        .miss_i(miss), .hit_i(hit), .busy_o(busy_p), .done_o(done_p), .addr_o(addr_p)
`ifdef CACHE_POLICY_STATS_EN
        , .stat_hits_o(hits_p), .stat_misses_o(misses_p)
`endif
    );

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    // Behavioural model: ways fill in order, so a set's valid ways are always 0..fill_cnt-1.
    int          phase;
    int          fill_cnt  [SETS];
    int          evict_cnt [SETS];
    bit          tree      [SETS][WAYS-1];
    int          pend_f, pend_p, m_addr_f, m_addr_p;
    int unsigned m_hits, m_misses;

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        phase    = 0;
        m_addr_f = 0;
        m_addr_p = 0;
        m_hits   = 0;
        m_misses = 0;
        for (int s = 0; s < SETS; s++) begin
            fill_cnt[s]  = 0;
            evict_cnt[s] = 0;
            for (int n = 0; n < WAYS - 1; n++) tree[s][n] = 1'b0;
        end
    endfunction

    // Level l of way w's path is node (2^l - 1) + (w >> (2 - l)); the node points at the other child.
    function automatic void tree_touch(input int s, input int w);
        for (int l = 0; l < 2; l++) begin
            tree[s][(1 << l) - 1 + (w >> (2 - l))] = (((w >> (1 - l)) & 1) == 0);
        end
    endfunction

    function automatic int tree_victim(input int s);
        int v = 0;
        for (int l = 0; l < 2; l++) v = v * 2 + int'(tree[s][(1 << l) - 1 + v]);
        return v;
    endfunction

    always @(posedge clock) begin
        int s, wf, wp;
        if (reset) begin
            model_reset();
        end else begin
            case (phase)
                0: begin
                    if (miss) begin
                        s = int'(access_addr[3:2]);
                        if (fill_cnt[s] < WAYS) begin
                            wf = fill_cnt[s];
                            wp = fill_cnt[s];
                            fill_cnt[s]++;
                        end else begin
                            wf = evict_cnt[s] % WAYS;
                            evict_cnt[s]++;
                            wp = tree_victim(s);
                        end
                        tree_touch(s, wp);
                        pend_f = s * WAYS + wf;
                        pend_p = s * WAYS + wp;
                        m_misses++;
                        phase = 1;
                    end else if (hit) begin
                        tree_touch(int'(cache_addr[3:2]), int'(cache_addr[1:0]));
                        m_hits++;
                    end
                end
                1: begin
                    m_addr_f = pend_f;
                    m_addr_p = pend_p;
                    phase    = 2;
                end
                default: phase = 0;
            endcase
        end
    end

    always @(posedge clock) begin
        #1;
        if (check_en) begin
            check_output("busy_fifo", int'(busy_f), int'(phase != 0));
            check_output("done_fifo", int'(done_f), int'(phase == 2));
            check_output("addr_fifo", int'(addr_f), m_addr_f);
            check_output("busy_plru", int'(busy_p), int'(phase != 0));
            check_output("done_plru", int'(done_p), int'(phase == 2));
            check_output("addr_plru", int'(addr_p), m_addr_p);
`ifdef CACHE_POLICY_STATS_EN
            check_output("stat_hits", int'(hits_f), int'(m_hits));
            check_output("stat_misses", int'(misses_p), int'(m_misses));
`endif
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        miss  = 1'b0;
        hit   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic issue_hit(input logic [3:0] a);
        @(negedge clock);
        hit        = 1'b1;
        cache_addr = a;
        @(negedge clock);
        hit = 1'b0;
    endtask

    // Pulse miss (optionally with a colliding hit), wait for done_o, then let the FSM return to IDLE.
    task automatic issue_miss(input logic [7:0] a, input bit with_hit, input logic [3:0] ha,
                              output int af, output int ap);
        bit got = 1'b0;
        af = -1;
        ap = -1;
        @(negedge clock);
        miss        = 1'b1;
        access_addr = a;
        hit         = with_hit;
        cache_addr  = ha;
        @(negedge clock);
        miss = 1'b0;
        hit  = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clock);
            #1;
            if (done_f) begin
                af  = int'(addr_f);
                ap  = int'(addr_p);
                got = 1'b1;
            end
        end
        check_output("done_timeout", int'(got), 1);
        @(posedge clock);
    endtask

    initial begin
        int af, ap;
        int exp_fifo [6] = '{0, 1, 2, 3, 0, 1};

        $display("[TB] start");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        check_en = 1'b1;
        @(posedge clock);
        #1;
        check_output("reset_busy", int'(busy_f), 0);
        check_output("reset_done", int'(done_p), 0);
        check_output("reset_addr", int'(addr_f), 0);

        for (int i = 0; i < 6; i++) begin
            issue_miss(8'h10, 1'b0, 4'h0, af, ap);
            check_output("fifo_set0", af, exp_fifo[i]);
        end
        issue_miss(8'h28, 1'b0, 4'h0, af, ap);
        check_output("fifo_set2", af, 8);

        apply_reset();
        for (int i = 0; i < 4; i++) begin
            issue_miss(8'h10, 1'b0, 4'h0, af, ap);
            check_output("plru_fill", ap, i);
        end
        issue_hit(4'h0);
        issue_miss(8'h10, 1'b0, 4'h0, af, ap);
        check_output("plru_after_hit0", ap, 2);
        issue_hit(4'h2);
        issue_miss(8'h10, 1'b0, 4'h0, af, ap);
        check_output("plru_after_hit2", ap, 1);

        apply_reset();
        for (int i = 0; i < 4; i++) issue_miss(8'h10, 1'b0, 4'h0, af, ap);
        issue_miss(8'h10, 1'b1, 4'h0, af, ap);
        check_output("collision_plru", ap, 0);

        // Miss held for two edges: only the first is accepted.
        apply_reset();
        @(negedge clock);
        miss        = 1'b1;
        access_addr = 8'h10;
        @(posedge clock);
        #1;
        check_output("timing_n_busy", int'(busy_f), 1);
        check_output("timing_n_done", int'(done_f), 0);
        @(posedge clock);
        #1;
        check_output("timing_n1_busy", int'(busy_f), 1);
        check_output("timing_n1_done", int'(done_f), 1);
        @(negedge clock);
        miss = 1'b0;
        @(posedge clock);
        #1;
        check_output("timing_n2_busy", int'(busy_f), 0);
        check_output("timing_n2_done", int'(done_f), 0);
        @(posedge clock);
        #1;
        check_output("timing_n3_done", int'(done_f), 0);

        // Reset arrives while the miss is in SELECT.
        apply_reset();
        @(negedge clock);
        miss        = 1'b1;
        access_addr = 8'h10;
        @(negedge clock);
        miss  = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("midreset_busy", int'(busy_f), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_output("midreset_done", int'(done_f), 0);
        end
        issue_miss(8'h10, 1'b0, 4'h0, af, ap);
        check_output("midreset_next_fifo", af, 0);
        check_output("midreset_next_plru", ap, 0);

`ifdef CACHE_POLICY_STATS_EN
        apply_reset();
        issue_hit(4'h1);
        issue_hit(4'h5);
        issue_hit(4'h9);
        issue_miss(8'h10, 1'b0, 4'h0, af, ap);
        issue_miss(8'h14, 1'b0, 4'h0, af, ap);
        issue_miss(8'h18, 1'b1, 4'h3, af, ap);
        check_output("stats_hits_lit", int'(hits_p), 3);
        check_output("stats_misses_lit", int'(misses_f), 3);
`endif

        // Random traffic, including requests while busy and occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            reset       = !reset && ($urandom_range(0, 149) == 0);
            miss        = ($urandom_range(0, 3) == 0);
            hit         = ($urandom_range(0, 2) == 0);
            access_addr = 8'($urandom);
            cache_addr  = 4'($urandom);
        end
        @(negedge clock);
        reset = 1'b0;
        miss  = 1'b0;
        hit   = 1'b0;
        repeat (5) @(posedge clock);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
